ascii_uart_tx: RTL and testbench
================================

// Module: ascii_uart_tx
// PURPOSE
//  Serialises the 4-char ASCII frame from the BCD-to-ASCII converter onto a UART line (8N1, LSB first).
//  Sits directly downstream of the converter: captures ascii_in on the ready_in pulse and sends chars MSB-byte first.
//  Optionally appends CR LF. Drives the board TX pin.
// PARAMETERS
//  CLKS_PER_BIT  868  clk cycles per UART bit (100 MHz / 115200); legal >= 2
//  APPEND_CRLF   1    1: send 0x0D,0x0A after the 4 digits; 0: digits only
// PORTS
//  clk        in   1   system clock, all logic on posedge
//  rst        in   1   asynchronous, active-low reset
//  ascii_in   in   32  chars, [31:24] sent first ... [7:0] sent last
//  ready_in   in   1   1-cycle frame-valid strobe from converter
//  tx         out  1   UART serial line, idle high
//  busy       out  1   high from the accepting cycle until the frame completes
//  frame_done out  1   1-cycle pulse when the last stop bit has finished
//  overrun    out  1   sticky: ready_in arrived while busy; cleared only by rst
// BEHAVIOUR
//  Reset (rst=0, async): tx=1, busy=0, frame_done=0, overrun=0, state=IDLE, all counters=0, frame buffer=0.
//  Reset mid-frame: tx returns to 1 at once; partial char is abandoned and not resumed.
//  FSM states: IDLE, START_BIT, DATA_BITS, STOP_BIT, NEXT_CHAR.
//   IDLE: ready_in=1 -> latch ascii_in (+CR,LF if APPEND_CRLF) into frame buffer, char_idx=0, busy=1 -> START_BIT.
//   START_BIT: tx=0 for CLKS_PER_BIT cycles -> DATA_BITS, bit_idx=0.
//   DATA_BITS: tx=cur_char[bit_idx], CLKS_PER_BIT cycles each; after bit 7 -> STOP_BIT.
//   STOP_BIT: tx=1 for CLKS_PER_BIT cycles -> NEXT_CHAR.
//   NEXT_CHAR (1 cycle, tx=1): if char_idx==LAST -> IDLE, frame_done=1, busy=0; else char_idx++ -> START_BIT.
//   LAST = 5 if APPEND_CRLF else 3.
//  Latency: ready_in high at edge N -> tx=0 from edge N+1 (all outputs registered).
//  Char period = 10*CLKS_PER_BIT + 1 cycles; frame = (LAST+1) char periods.
//  Baud counter: 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. Width $clog2(CLKS_PER_BIT).
//  char_idx is 3 bits; bit_idx is 3 bits. Neither counter exceeds its limit and neither wraps.
//  ready_in while busy (including the NEXT_CHAR cycle that returns to IDLE):
//   - frame is ignored and the buffer is untouched
//   - overrun <= 1
//  ready_in in IDLE in the same cycle that frame_done would be seen: not possible.
//   frame_done is asserted on the IDLE-entry edge, so a strobe at that edge counts as busy.
//  ready_in held high for >1 cycle in IDLE:
//   - only the first cycle is accepted
//   - the rest fall while busy and set overrun
//  ascii_in may change freely after the accept cycle.
//  No content checking: any byte is sent verbatim.
// STRUCTURE
//  Package uart_pkg:
//   - typedef enum logic [2:0] tx_state_t
//   - localparams ASCII_CR=8'h0D, ASCII_LF=8'h0A, UART_DATA_BITS=8
//  Sub-module baud_tick_gen #(CLKS_PER_BIT) (clk, rst, en, tick):
//   - counter cleared while en=0
//   - tick is 1 cycle at the end of each bit period
//  One always_ff for state, one always_comb for next state, one always_ff for datapath/outputs.
// TESTING (CLKS_PER_BIT=4 unless stated)
//  1. rst low 3 cycles, then high:
//     - tx=1, busy=0, frame_done=0, overrun=0 throughout
//     - tx stays 1 with no ready_in
//  2. ascii_in=32'h31323334 ("1234"), APPEND_CRLF=0, one ready_in pulse:
//     - tx decodes to 0x31,0x32,0x33,0x34
//     - first start bit at edge N+1
//     - frame_done pulses exactly 4*41 cycles after accept, then busy=0
//  3. Same input, APPEND_CRLF=1:
//     - decoded bytes 31 32 33 34 0D 0A
//     - frame_done at 6*41 cycles
//  4. Second ready_in (ascii_in=32'h39393939) 50 cycles into frame:
//     - the first frame is sent unchanged
//     - overrun=1 and stays 1
//     - no '9' bytes appear
//  5. rst asserted during DATA_BITS of char 2:
//     - tx=1 immediately, busy=0
//     - after release, a new "0042" frame sends correctly and overrun=0
//  6. Back-to-back: ready_in exactly 1 cycle after frame_done:
//     - accepted with no overrun
//     - tx start bit on the next edge

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the ASCII UART transmitter
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA_BITS = 3'd2,
    STOP_BIT  = 3'd3,
    NEXT_CHAR = 3'd4
  } tx_state_t;

  localparam logic [7:0] ASCII_CR       = 8'h0D;
  localparam logic [7:0] ASCII_LF       = 8'h0A;
  localparam int         UART_DATA_BITS = 8;

endpackage

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - bit-period counter, one-cycle tick at the end of each bit
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int              CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   CNT_MAX = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ascii_uart_tx.sv
// rtl/ascii_uart_tx.sv - sends a captured 4-char ASCII frame (plus optional CR LF) as 8N1 UART
module ascii_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter bit APPEND_CRLF  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ascii_in,
  input  logic        ready_in,
  output logic        tx,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

  localparam logic [2:0] LAST     = APPEND_CRLF ? 3'd5 : 3'd3;
  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  tx_state_t  state, state_nxt;
  logic [7:0] frame_buf [6];
  logic [2:0] char_idx;
  logic [2:0] bit_idx;
  logic [2:0] bit_idx_nxt;
  logic [7:0] cur_char;
  logic       tick;
  logic       baud_en;

  assign baud_en     = (state == START_BIT) || (state == DATA_BITS) || (state == STOP_BIT);
  assign bit_idx_nxt = bit_idx + 3'd1;

  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .en   (baud_en),
    .tick (tick)
  );

  always_comb begin
    cur_char = 8'h00;
    case (char_idx)
      3'd0:    cur_char = frame_buf[0];
      3'd1:    cur_char = frame_buf[1];
      3'd2:    cur_char = frame_buf[2];
      3'd3:    cur_char = frame_buf[3];
      3'd4:    cur_char = frame_buf[4];
      3'd5:    cur_char = frame_buf[5];
      default: cur_char = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (ready_in) state_nxt = START_BIT;
      START_BIT: if (tick) state_nxt = DATA_BITS;
      DATA_BITS: if (tick && (bit_idx == LAST_BIT)) state_nxt = STOP_BIT;
      STOP_BIT:  if (tick) state_nxt = NEXT_CHAR;
      NEXT_CHAR: state_nxt = (char_idx == LAST) ? IDLE : START_BIT;
      default:   state_nxt = IDLE;
    endcase
  end

  // tx is registered alongside the state so the line moves on the same edge as the FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      char_idx   <= 3'd0;
      bit_idx    <= 3'd0;
      for (int i = 0; i < 6; i++) frame_buf[i] <= 8'h00;
    end else begin
      frame_done <= 1'b0;
      if (ready_in && (state != IDLE)) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (ready_in) begin
            frame_buf[0] <= ascii_in[31:24];
            frame_buf[1] <= ascii_in[23:16];
            frame_buf[2] <= ascii_in[15:8];
            frame_buf[3] <= ascii_in[7:0];
            frame_buf[4] <= APPEND_CRLF ? ASCII_CR : 8'h00;
            frame_buf[5] <= APPEND_CRLF ? ASCII_LF : 8'h00;
            char_idx     <= 3'd0;
            busy         <= 1'b1;
            tx           <= 1'b0;
          end
        end
        START_BIT: begin
          if (tick) begin
            bit_idx <= 3'd0;
            tx      <= cur_char[0];
          end
        end
        DATA_BITS: begin
          if (tick) begin
            if (bit_idx == LAST_BIT) begin
              tx <= 1'b1;
            end else begin
              bit_idx <= bit_idx_nxt;
              tx      <= cur_char[bit_idx_nxt];
            end
          end
        end
        STOP_BIT: tx <= 1'b1;
        NEXT_CHAR: begin
          if (char_idx == LAST) begin
            busy       <= 1'b0;
            frame_done <= 1'b1;
            tx         <= 1'b1;
          end else begin
            char_idx <= char_idx + 3'd1;
            tx       <= 1'b0;
          end
        end
        default: tx <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_ascii_uart_tx.sv
// tb/tb_ascii_uart_tx.sv - randomized bench for ascii_uart_tx against a cycle-position model
module tb_ascii_uart_tx;

  localparam int C = 4;
  localparam int P = 10 * C + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] ascii_in = 32'h0;
  logic        ready_in = 1'b0;
  logic [1:0]  tx, busy, fd, ovr;

  ascii_uart_tx #(.CLKS_PER_BIT(C), .APPEND_CRLF(1'b0)) dut0 (
    .clk(clk), .rst(rst), .ascii_in(ascii_in), .ready_in(ready_in),
    .tx(tx[0]), .busy(busy[0]), .frame_done(fd[0]), .overrun(ovr[0])
  );

  ascii_uart_tx #(.CLKS_PER_BIT(C), .APPEND_CRLF(1'b1)) dut1 (
    .clk(clk), .rst(rst), .ascii_in(ascii_in), .ready_in(ready_in),
    .tx(tx[1]), .busy(busy[1]), .frame_done(fd[1]), .overrun(ovr[1])
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // model: position m (cycles since the accept edge) fully determines every output
  int         cyc = 0;
  bit         m_act [2];
  int         m_m [2];
  logic [7:0] m_bytes [2][6];
  bit         m_ovr [2];
  bit         m_bz;
  int         acc_cyc [2];
  int         fd_cyc [2];

  function automatic int nch(input int i);
    return (i != 0) ? 6 : 4;
  endfunction

  function automatic logic exp_tx(input int i, input int m);
    int ch, off, b;
    ch  = m / P;
    off = m % P;
    if (off >= 10 * C) return 1'b1;
    b = off / C;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_bytes[i][ch][b-1];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] = 1'b0;
        m_ovr[i] = 1'b0;
        m_m[i]   = 0;
      end
    end else begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
        m_bz = m_act[i] && (m_m[i] < nch(i) * P);
        if (ready_in && m_bz) begin
          m_ovr[i] = 1'b1;
          m_m[i]++;
        end else if (ready_in) begin
          m_act[i]   = 1'b1;
          m_m[i]     = 0;
          acc_cyc[i] = cyc;
          for (int j = 0; j < 4; j++) m_bytes[i][j] = ascii_in[31-8*j -: 8];
          m_bytes[i][4] = 8'h0D;
          m_bytes[i][5] = 8'h0A;
        end else if (m_act[i]) begin
          if (m_m[i] >= nch(i) * P) m_act[i] = 1'b0;
          else m_m[i]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic et, eb, ef;
      if (!rst || !m_act[i] || (m_m[i] > nch(i) * P)) begin
        et = 1'b1; eb = 1'b0; ef = 1'b0;
      end else if (m_m[i] == nch(i) * P) begin
        et = 1'b1; eb = 1'b0; ef = 1'b1;
      end else begin
        et = exp_tx(i, m_m[i]); eb = 1'b1; ef = 1'b0;
      end
      chk($sformatf("tx[%0d] cyc %0d", i, cyc), 32'(tx[i]), 32'(et));
      chk($sformatf("busy[%0d] cyc %0d", i, cyc), 32'(busy[i]), 32'(eb));
      chk($sformatf("frame_done[%0d] cyc %0d", i, cyc), 32'(fd[i]), 32'(ef));
      chk($sformatf("overrun[%0d] cyc %0d", i, cyc), 32'(ovr[i]), 32'(rst ? m_ovr[i] : 1'b0));
      if (fd[i] === 1'b1) fd_cyc[i] = cyc;
    end
  end

  // line decoder: recovers bytes from tx by mid-bit sampling
  logic [7:0] dq [2][$];
  bit         d_busy [2];
  int         d_cnt [2];
  logic [7:0] d_sh [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        d_busy[i] = 1'b0;
      end else if (!d_busy[i]) begin
        if (tx[i] == 1'b0) begin
          d_busy[i] = 1'b1;
          d_cnt[i]  = 0;
        end
      end else begin
        d_cnt[i]++;
        if ((d_cnt[i] % C == C / 2) && (d_cnt[i] / C >= 1) && (d_cnt[i] / C <= 8))
          d_sh[i][d_cnt[i] / C - 1] = tx[i];
        if (d_cnt[i] == 9 * C + C / 2) begin
          if (tx[i] == 1'b1) dq[i].push_back(d_sh[i]);
          d_busy[i] = 1'b0;
        end
      end
    end
  end

  task automatic pulse(input logic [31:0] a, input int len = 1);
    @(posedge clk); #2;
    ascii_in = a;
    ready_in = 1'b1;
    repeat (len) @(posedge clk);
    #2;
    ready_in = 1'b0;
    ascii_in = $urandom;
  endtask

  task automatic wait_fd(input int i, input int budget);
    bit got;
    got = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk); #1;
      if (fd[i] === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk($sformatf("wait frame_done[%0d]", i), 32'(got), 32'd1);
  endtask

  task automatic chk_bytes(input int i, input int n, input logic [7:0] e [6]);
    chk($sformatf("byte count[%0d]", i), 32'(dq[i].size()), 32'(n));
    for (int k = 0; k < n; k++)
      if (k < dq[i].size()) chk($sformatf("byte[%0d][%0d]", i, k), 32'(dq[i][k]), 32'(e[k]));
  endtask

  logic [7:0] e_1234 [6];
  logic [7:0] e_0042 [6];
  logic [7:0] e_abcd [6];

  initial begin
    e_1234 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A};
    e_0042 = '{8'h30, 8'h30, 8'h34, 8'h32, 8'h0D, 8'h0A};
    e_abcd = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h00, 8'h00};

    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    repeat (12) @(posedge clk);
    #3;
    chk("idle tx", 32'(tx), 32'h3);
    chk("idle busy", 32'(busy), 32'h0);

    // single frame on both variants
    dq[0].delete(); dq[1].delete();
    pulse(32'h31323334);
    wait_fd(0, 400);
    chk("frame_done latency no crlf", 32'(fd_cyc[0] - acc_cyc[0]), 32'd164);
    wait_fd(1, 400);
    chk("frame_done latency crlf", 32'(fd_cyc[1] - acc_cyc[1]), 32'd246);
    chk_bytes(0, 4, e_1234);
    chk_bytes(1, 6, e_1234);
    chk("no overrun after clean frame", 32'(ovr), 32'h0);

    // strobe mid-frame is dropped and flagged
    repeat (5) @(posedge clk);
    dq[0].delete(); dq[1].delete();
    pulse(32'h31323334);
    repeat (48) @(posedge clk);
    pulse(32'h39393939);
    wait_fd(0, 400);
    wait_fd(1, 400);
    chk_bytes(0, 4, e_1234);
    chk_bytes(1, 6, e_1234);
    repeat (20) @(posedge clk);
    #3 chk("overrun sticky", 32'(ovr), 32'h3);

    // reset during data bits of char 2
    pulse(32'h31323334);
    repeat (2 * P + 12) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("reset tx", 32'(tx), 32'h3);
    chk("reset busy", 32'(busy), 32'h0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    dq[0].delete(); dq[1].delete();
    pulse(32'h30303432);
    wait_fd(0, 400);
    wait_fd(1, 400);
    chk_bytes(0, 4, e_0042);
    chk_bytes(1, 6, e_0042);
    chk("overrun cleared by reset", 32'(ovr), 32'h0);

    // back-to-back: strobe sampled on the edge after frame_done
    repeat (5) @(posedge clk);
    pulse(32'h31323334);
    wait_fd(0, 400);
    dq[0].delete();
    ascii_in = 32'h41424344;
    ready_in = 1'b1;
    @(posedge clk); #2;
    ready_in = 1'b0;
    @(negedge clk); #1;
    chk("back-to-back start bit", 32'(tx[0]), 32'h0);
    chk("back-to-back busy", 32'(busy[0]), 32'h1);
    chk("back-to-back no overrun", 32'(ovr[0]), 32'h0);
    wait_fd(0, 400);
    chk_bytes(0, 4, e_abcd);

    // random frames, gaps and held strobes
    for (int r = 0; r < 30; r++) begin
      pulse($urandom, ($urandom_range(0, 3) == 0) ? $urandom_range(2, 3) : 1);
      repeat ($urandom_range(0, 300)) @(posedge clk);
    end
    repeat (300) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
